// File: rtl/cnn_layer_accel_weight_seq_walker_if.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_weight_seq_walker_if
//
// Bundles the control, table-read and weight-address stream signals of the
// weight-sequence walker.
//   master : the walker itself (drives busy/done, table read request and the
//            weight-address stream).
//   slave  : the environment (layer controller, sequence table, weight-RAM
//            read port).
//
// Signals
//   start, num_kernels, wht_base_addr : walk request from the layer controller
//   busy, done                        : walk status back to the controller
//   tbl_rdAddr, tbl_rden              : sequence-table read request
//   tbl_dout0, tbl_dout1              : table data, valid the cycle after rden
//   wht_addr0/1, wht_valid, wht_last  : weight-address pair stream
//   wht_ready                         : downstream accept
//   seq_err                           : sticky range-error flag
// -----------------------------------------------------------------------------
interface cnn_layer_accel_weight_seq_walker_if #(
  parameter int C_NUM_SEQ        = 5,
  parameter int C_SEQ_WIDTH      = 4,
  parameter int C_KRNL_CNT_WIDTH = 10,
  parameter int C_WHT_ADDR_WIDTH = 16
);
  localparam int C_TBL_ADDR_W = (C_NUM_SEQ > 1) ? $clog2(C_NUM_SEQ) : 1;

  logic                        start;
  logic [C_KRNL_CNT_WIDTH-1:0] num_kernels;
  logic [C_WHT_ADDR_WIDTH-1:0] wht_base_addr;
  logic                        busy;
  logic                        done;
  logic [C_TBL_ADDR_W-1:0]     tbl_rdAddr;
  logic                        tbl_rden;
  logic [C_SEQ_WIDTH-1:0]      tbl_dout0;
  logic [C_SEQ_WIDTH-1:0]      tbl_dout1;
  logic [C_WHT_ADDR_WIDTH-1:0] wht_addr0;
  logic [C_WHT_ADDR_WIDTH-1:0] wht_addr1;
  logic                        wht_valid;
  logic                        wht_ready;
  logic                        wht_last;
  logic                        seq_err;

  modport master (
    input  start, num_kernels, wht_base_addr, tbl_dout0, tbl_dout1, wht_ready,
    output busy, done, tbl_rdAddr, tbl_rden, wht_addr0, wht_addr1, wht_valid,
           wht_last, seq_err
  );

  modport slave (
    output start, num_kernels, wht_base_addr, tbl_dout0, tbl_dout1, wht_ready,
    input  busy, done, tbl_rdAddr, tbl_rden, wht_addr0, wht_addr1, wht_valid,
           wht_last, seq_err
  );
endinterface

// File: rtl/cnn_layer_accel_weight_seq_walker.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_weight_seq_walker
//
// Walks the weight-sequence table once per kernel and turns every table entry
// pair into two weight-RAM addresses:
//   wht_addrN = base + kernel * C_KRNL_SIZE + tbl_doutN   (mod 2^C_WHT_ADDR_WIDTH)
// Table reads have one cycle of latency; returned data is converted and pushed
// into a 2-entry FIFO whose head drives the valid/ready address stream.
//
// Ports
//   clk, rst : clock and synchronous active-high reset
//   bus      : master side of cnn_layer_accel_weight_seq_walker_if
//
// Build option
//   CNN_LAYER_ACCEL_WHT_SEQ_RANGE_CHECK_EN : when defined, table offsets
//   >= C_KRNL_SIZE are replaced by 0 and raise a sticky seq_err (cleared by
//   the next accepted start). When undefined, seq_err is tied to 0.
// -----------------------------------------------------------------------------
module cnn_layer_accel_weight_seq_walker #(
  parameter int C_NUM_SEQ        = 5,
  parameter int C_SEQ_WIDTH      = 4,
  parameter int C_KRNL_SIZE      = 9,
  parameter int C_KRNL_CNT_WIDTH = 10,
  parameter int C_WHT_ADDR_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  cnn_layer_accel_weight_seq_walker_if.master  bus
);

  localparam int C_TBL_ADDR_W = (C_NUM_SEQ > 1) ? $clog2(C_NUM_SEQ) : 1;
  localparam int C_CALC_W     = C_WHT_ADDR_WIDTH + C_KRNL_CNT_WIDTH + 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [C_KRNL_CNT_WIDTH-1:0] num_kernels_q, num_kernels_d;
  logic [C_WHT_ADDR_WIDTH-1:0] base_q, base_d;
  logic [C_TBL_ADDR_W-1:0]     entry_q, entry_d;
  logic [C_KRNL_CNT_WIDTH-1:0] kernel_q, kernel_d;
  logic                        start_acc;

  // One-stage tag pipe travelling alongside the table read.
  logic                        inflight_q;
  logic [C_KRNL_CNT_WIDTH-1:0] tag_kernel_q;
  logic                        tag_last_q;

  // Output FIFO (2 entries).
  logic [C_WHT_ADDR_WIDTH-1:0] addr0_mem_q [2];
  logic [C_WHT_ADDR_WIDTH-1:0] addr1_mem_q [2];
  logic                        last_mem_q  [2];
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  count_q;

  logic                        push, pop, rden, last_rd;
  logic [2:0]                  occupancy;
  logic [C_SEQ_WIDTH-1:0]      off0, off1;
  logic [C_CALC_W-1:0]         krnl_off;
  logic [C_WHT_ADDR_WIDTH-1:0] push_addr0, push_addr1;

  assign pop  = (count_q != 2'd0) && bus.wht_ready;
  assign push = inflight_q;

  // Entries already held plus the read still returning, minus the one leaving
  // now: issuing only while this is below 2 guarantees the FIFO cannot overflow
  // and still allows one read per cycle when the stream is flowing.
  assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign rden      = (state_q == S_RUN) && (occupancy < 3'd2);
  assign last_rd   = (entry_q == C_TBL_ADDR_W'(C_NUM_SEQ - 1)) &&
                     (kernel_q == num_kernels_q - C_KRNL_CNT_WIDTH'(1));

  // ---------------------------------------------------------------------------
  // Offset range check
  // ---------------------------------------------------------------------------
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_RANGE_CHECK_EN
  logic bad0, bad1;
  logic err_mem_q [2];
  logic seq_err_q;

  assign bad0 = C_CALC_W'(bus.tbl_dout0) >= C_CALC_W'(C_KRNL_SIZE);
  assign bad1 = C_CALC_W'(bus.tbl_dout1) >= C_CALC_W'(C_KRNL_SIZE);
  assign off0 = bad0 ? '0 : bus.tbl_dout0;
  assign off1 = bad1 ? '0 : bus.tbl_dout1;

  // The flag rises in the same cycle the offending pair is accepted, then
  // holds until the next accepted start.
  assign bus.seq_err = seq_err_q | (pop & err_mem_q[rd_ptr_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_q <= 1'b0;
      err_mem_q <= '{default: 1'b0};
    end else begin
      if (push)
        err_mem_q[wr_ptr_q] <= bad0 | bad1;
      if (start_acc)
        seq_err_q <= 1'b0;
      else if (pop && err_mem_q[rd_ptr_q])
        seq_err_q <= 1'b1;
    end
  end
`else
  assign off0        = bus.tbl_dout0;
  assign off1        = bus.tbl_dout1;
  assign bus.seq_err = 1'b0;
`endif

  // Computed wide, then truncated: addresses wrap modulo 2^C_WHT_ADDR_WIDTH.
  assign krnl_off   = C_CALC_W'(tag_kernel_q) * C_CALC_W'(C_KRNL_SIZE);
  assign push_addr0 = C_WHT_ADDR_WIDTH'(C_CALC_W'(base_q) + krnl_off + C_CALC_W'(off0));
  assign push_addr1 = C_WHT_ADDR_WIDTH'(C_CALC_W'(base_q) + krnl_off + C_CALC_W'(off1));

  // ---------------------------------------------------------------------------
  // FSM and walk counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    state_d       = state_q;
    num_kernels_d = num_kernels_q;
    base_d        = base_q;
    entry_d       = entry_q;
    kernel_d      = kernel_q;
    start_acc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          start_acc     = 1'b1;
          num_kernels_d = bus.num_kernels;
          base_d        = bus.wht_base_addr;
          entry_d       = '0;
          kernel_d      = '0;
          state_d       = (bus.num_kernels == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rden) begin
          if (last_rd) begin
            state_d = S_DRAIN;
          end else if (entry_q == C_TBL_ADDR_W'(C_NUM_SEQ - 1)) begin
            entry_d  = '0;
            kernel_d = kernel_q + C_KRNL_CNT_WIDTH'(1);
          end else begin
            entry_d = entry_q + C_TBL_ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final pair is accepted so done follows it by one cycle.
        if (!inflight_q && (count_q == 2'(pop)))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      num_kernels_q <= '0;
      base_q        <= '0;
      entry_q       <= '0;
      kernel_q      <= '0;
      inflight_q    <= 1'b0;
      tag_kernel_q  <= '0;
      tag_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_kernels_q <= num_kernels_d;
      base_q        <= base_d;
      entry_q       <= entry_d;
      kernel_q      <= kernel_d;
      inflight_q    <= rden;
      if (rden) begin
        tag_kernel_q <= kernel_q;
        tag_last_q   <= last_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset because its head drives wht_addr0/1
      // directly and those outputs must read 0 out of reset.
      addr0_mem_q <= '{default: '0};
      addr1_mem_q <= '{default: '0};
      last_mem_q  <= '{default: 1'b0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        addr0_mem_q[wr_ptr_q] <= push_addr0;
        addr1_mem_q[wr_ptr_q] <= push_addr1;
        last_mem_q[wr_ptr_q]  <= tag_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.tbl_rden   = rden;
  assign bus.tbl_rdAddr = entry_q;
  assign bus.wht_valid  = (count_q != 2'd0);
  assign bus.wht_addr0  = addr0_mem_q[rd_ptr_q];
  assign bus.wht_addr1  = addr1_mem_q[rd_ptr_q];
  assign bus.wht_last   = last_mem_q[rd_ptr_q] & bus.wht_valid;

endmodule
